// File: rtl/strip_frame_buffer_if.sv
// Pixel write / clear / commit port of the strip frame buffer.
// The producer (pattern generator, UART loader) is the master; the buffer is the slave.
interface strip_frame_buffer_if #(
    parameter int IDX_W = 3
);
    logic             wr_valid;
    logic             wr_ready;
    logic [IDX_W-1:0] wr_index;
    logic [23:0]      wr_color;
    logic             clear;
    logic             commit;

    modport master (
        output wr_valid, wr_index, wr_color, clear, commit,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_index, wr_color, clear, commit,
        output wr_ready
    );
endinterface

// File: rtl/strip_frame_buffer.sv
// Double-buffered LED colour store. Writes land in the back bank; a commit copies
// back -> front during the encoder's inter-frame gap so the strip never sees a torn frame.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no swap outstanding; writes, clears and commits are accepted
// ST_PEND | commit accepted; back bank frozen until the encoder goes idle
module strip_frame_buffer #(
    parameter int LENGTH = 5,
    parameter int IDX_W  = $clog2(LENGTH + 1),
    parameter int CNT_W  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    strip_frame_buffer_if.slave   wr_if,
    input  logic                  sending_data_i,
    output logic [LENGTH*24-1:0]  strip_o,
    output logic                  commit_pend_o,
    output logic                  err_oob_o,
    output logic [CNT_W-1:0]      frame_count_o
);

    typedef enum logic {ST_IDLE, ST_PEND} state_t;

    state_t           state_q;
    logic             sd_meta_q;
    logic             sd_sync_q;
    logic [23:0]      back_q  [LENGTH];
    logic [23:0]      back_d  [LENGTH];
    logic [23:0]      front_q [LENGTH];
    logic             err_oob_q;
    logic             err_oob_d;
    logic [CNT_W-1:0] frame_count_q;
    logic             idx_oob;

    assign idx_oob        = (wr_if.wr_index >= IDX_W'(LENGTH));
    assign wr_if.wr_ready = !rst_i && (state_q == ST_IDLE);

    // Back bank after this cycle's clear and write; clear applies first so a
    // same-cycle write survives it.
    always_comb begin
        back_d    = back_q;
        err_oob_d = err_oob_q;
        if (wr_if.clear) begin
            for (int i = 0; i < LENGTH; i++) back_d[i] = '0;
        end
        if (wr_if.wr_valid) begin
            if (idx_oob) begin
                err_oob_d = 1'b1;
            end else begin
                for (int i = 0; i < LENGTH; i++) begin
                    if (wr_if.wr_index == IDX_W'(i)) back_d[i] = wr_if.wr_color;
                end
            end
        end
    end

    // Busy-flag synchronizer, bank updates and the commit/swap state machine.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            sd_meta_q     <= 1'b1;
            sd_sync_q     <= 1'b1;
            err_oob_q     <= 1'b0;
            frame_count_q <= '0;
            for (int i = 0; i < LENGTH; i++) begin
                back_q[i]  <= '0;
                front_q[i] <= '0;
            end
        end else begin
            sd_meta_q <= sending_data_i;
            sd_sync_q <= sd_meta_q;
            case (state_q)
                ST_IDLE: begin
                    back_q    <= back_d;
                    err_oob_q <= err_oob_d;
                    if (wr_if.commit) state_q <= ST_PEND;
                end
                ST_PEND: begin
                    if (!sd_sync_q) begin
                        front_q       <= back_q;
                        frame_count_q <= frame_count_q + CNT_W'(1);
                        state_q       <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Flatten the front bank; LED 0 sits in the low 24 bits.
    always_comb begin
        strip_o = '0;
        for (int i = 0; i < LENGTH; i++) strip_o[i*24 +: 24] = front_q[i];
    end

    assign commit_pend_o = (state_q == ST_PEND);
    assign err_oob_o     = err_oob_q;
    assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_strip_frame_buffer.sv
// Self-checking bench for strip_frame_buffer: directed scenarios plus a random phase,
// every cycle compared against a frame-level reference model.
module tb_strip_frame_buffer;
    localparam int LENGTH = 5;
    localparam int IDX_W  = 3;
    localparam int CNT_W  = 10;   // narrow counter so the wrap is reachable quickly
    localparam int SW     = LENGTH * 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             sd;
    logic [SW-1:0]    strip;
    logic             pend_o;
    logic             err_o;
    logic [CNT_W-1:0] fc_o;

    strip_frame_buffer_if #(.IDX_W(IDX_W)) bus ();

    strip_frame_buffer #(.LENGTH(LENGTH), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .wr_if          (bus.slave),
        .sending_data_i (sd),
        .strip_o        (strip),
        .commit_pend_o  (pend_o),
        .err_oob_o      (err_o),
        .frame_count_o  (fc_o)
    );

    // reference model
    logic [23:0] m_back  [LENGTH];
    logic [23:0] m_front [LENGTH];
    bit          m_pend;
    bit          m_err;
    int          m_swaps;
    bit          sd_hist [2];   // busy flag as seen one and two edges ago

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [SW-1:0] m_strip();
        logic [SW-1:0] s;
        s = '0;
        for (int i = 0; i < LENGTH; i++) s[i*24 +: 24] = m_front[i];
        return s;
    endfunction

    task automatic model_edge();
        bit gap;
        if (rst) begin
            for (int i = 0; i < LENGTH; i++) begin
                m_back[i]  = '0;
                m_front[i] = '0;
            end
            m_pend     = 0;
            m_err      = 0;
            m_swaps    = 0;
            sd_hist[0] = 1;
            sd_hist[1] = 1;
        end else begin
            gap = (sd_hist[1] == 0);
            if (!m_pend) begin
                if (bus.clear)
                    for (int i = 0; i < LENGTH; i++) m_back[i] = '0;
                if (bus.wr_valid) begin
                    if (int'(bus.wr_index) < LENGTH) m_back[bus.wr_index] = bus.wr_color;
                    else m_err = 1;
                end
                if (bus.commit) m_pend = 1;
            end else if (gap) begin
                for (int i = 0; i < LENGTH; i++) m_front[i] = m_back[i];
                m_pend = 0;
                m_swaps++;
            end
            sd_hist[1] = sd_hist[0];
            sd_hist[0] = sd;
        end
    endtask

    task automatic check_all();
        chk("strip", strip, m_strip());
        chk("commit_pend", pend_o, m_pend);
        chk("err_oob", err_o, m_err);
        chk("frame_count", fc_o, m_swaps % (1 << CNT_W));
        chk("wr_ready", bus.wr_ready, !rst && !m_pend);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_in();
        bus.wr_valid = 0;
        bus.clear    = 0;
        bus.commit   = 0;
        bus.wr_index = '0;
        bus.wr_color = '0;
    endtask

    task automatic wr(input int idx, input logic [23:0] col);
        bus.wr_valid = 1;
        bus.wr_index = IDX_W'(idx);
        bus.wr_color = col;
    endtask

    logic [SW-1:0]    saved_strip;
    logic [CNT_W-1:0] saved_fc;

    initial begin
        rst = 1;
        sd  = 1;
        idle_in();
        #2;

        // T1: reset with random inputs
        for (int k = 0; k < 2; k++) begin
            bus.wr_valid = 1'($urandom);
            bus.wr_index = IDX_W'($urandom_range(0, 4));
            bus.wr_color = 24'($urandom);
            bus.clear    = 1'($urandom);
            bus.commit   = 1'($urandom);
            sd           = 1'($urandom);
            cyc();
            chk("t1_ready_in_rst", bus.wr_ready, 1'b0);
            chk("t1_strip", strip, '0);
        end
        rst = 0;
        idle_in();
        sd = 0;
        #1;
        chk("t1_ready_after", bus.wr_ready, 1'b1);
        chk("t1_err", err_o, 1'b0);
        repeat (3) cyc();

        // T2: basic write + commit, swap on the following edge
        wr(0, 24'hFF0000); cyc();
        wr(4, 24'h0000FF); cyc();
        idle_in(); bus.commit = 1; cyc();
        chk("t2_pend", pend_o, 1'b1);
        idle_in(); cyc();
        chk("t2_led0", strip[23:0], 24'hFF0000);
        chk("t2_led4", strip[119:96], 24'h0000FF);
        chk("t2_fc", fc_o, 1);
        chk("t2_pend_clr", pend_o, 1'b0);

        // T3: swap held off while the encoder is busy
        sd = 1;
        repeat (3) cyc();
        bus.commit = 1; cyc();
        chk("t3_pend", pend_o, 1'b1);
        chk("t3_ready", bus.wr_ready, 1'b0);
        saved_strip = strip;
        saved_fc    = fc_o;
        for (int k = 0; k < 100; k++) begin
            wr($urandom_range(0, 4), 24'($urandom));
            bus.clear = 1'($urandom);
            cyc();
        end
        chk("t3_strip_held", strip, saved_strip);
        idle_in();
        sd = 0;
        cyc(); cyc();
        chk("t3_not_yet", pend_o, 1'b1);
        cyc();
        chk("t3_swapped", pend_o, 1'b0);
        chk("t3_fc", fc_o, saved_fc + CNT_W'(1));

        // T4: out-of-range write, then commit with a same-cycle write
        wr(5, 24'h123456); cyc();
        chk("t4_err", err_o, 1'b1);
        wr(1, 24'h777777); bus.commit = 1; cyc();
        idle_in(); cyc();
        chk("t4_led1", strip[47:24], 24'h777777);
        chk("t4_err_sticky", err_o, 1'b1);

        // T5: clear + write + commit in one cycle; a second commit while pending is dropped
        sd = 1;
        repeat (2) cyc();
        saved_fc = fc_o;
        wr(2, 24'hABCDEF); bus.clear = 1; bus.commit = 1; cyc();
        idle_in(); bus.commit = 1; cyc();
        idle_in(); sd = 0;
        repeat (4) cyc();
        chk("t5_strip", strip, {24'h0, 24'h0, 24'hABCDEF, 24'h0, 24'h0});
        chk("t5_fc", fc_o, saved_fc + CNT_W'(1));

        // T6: reset while pending, then drive the frame counter through its wrap
        sd = 1;
        repeat (2) cyc();
        bus.commit = 1; cyc();
        idle_in(); rst = 1; cyc();
        rst = 0; sd = 0;
        repeat (3) cyc();
        chk("t6_strip", strip, '0);
        chk("t6_fc", fc_o, 0);
        chk("t6_pend", pend_o, 1'b0);
        wr(3, 24'h00FF00);
        bus.commit = 1;
        for (int k = 0; k < 2 * (1 << CNT_W); k++) begin
            cyc();
            bus.wr_valid = 0;
        end
        idle_in();
        #1;
        chk("t6_wrap", fc_o, 0);
        chk("t6_wrap_pend", pend_o, 1'b0);

        // random phase
        for (int k = 0; k < 3000; k++) begin
            rst          = ($urandom_range(0, 99) == 0);
            bus.wr_valid = 1'($urandom);
            bus.wr_index = IDX_W'($urandom_range(0, 6));
            bus.wr_color = 24'($urandom);
            bus.clear    = ($urandom_range(0, 15) == 0);
            bus.commit   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) sd = ~sd;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end expected end of test");
        $fatal(1);
    end
endmodule
